// File: rtl/rx_ctr_reporter.sv
// Snapshots the per-port rx packet counters and streams them as a framed 64-bit AXI-stream report.
// Optional RX_CTR_DELTA_EN: beats carry (snapshot - previous snapshot) instead of absolute values.
module rx_ctr_reporter #(
    parameter int NUM_PORTS     = 2,
    parameter int PERIOD_CYCLES = 250000000,
    parameter int PW            = 32
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    enable,
    input  logic                    trigger,
    input  logic [64*NUM_PORTS-1:0] bad_packets_in,
    input  logic [64*NUM_PORTS-1:0] fd_packets_in,
    input  logic [64*NUM_PORTS-1:0] md_packets_in,
    input  logic [64*NUM_PORTS-1:0] fc_packets_in,
    input  logic [64*NUM_PORTS-1:0] oth_packets_in,
    output logic [63:0]             axis_out_tdata,
    output logic                    axis_out_tvalid,
    output logic                    axis_out_tlast,
    input  logic                    axis_out_tready,
    output logic                    busy,
    output logic [31:0]             report_seq,
    output logic [31:0]             dropped_triggers
);

    localparam int NUM_CTRS = 5 * NUM_PORTS;
    localparam int IW       = $clog2(NUM_CTRS);
    localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_CTRS - 1);
    localparam logic [PW-1:0] TIMER_LAST = PW'(PERIOD_CYCLES - 1);
`ifdef RX_CTR_DELTA_EN
    localparam logic [7:0] HDR_FLAGS = 8'h01;
`else
    localparam logic [7:0] HDR_FLAGS = 8'h00;
`endif

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SNAP   = 2'd1,
        ST_HEADER = 2'd2,
        ST_SEND   = 2'd3
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic [PW-1:0]   timer_r;
    logic [IW-1:0]   idx_r;
    logic [IW-1:0]   next_idx_s;
    logic [63:0]     snap_r [NUM_CTRS];
`ifdef RX_CTR_DELTA_EN
    logic [63:0]     prev_r [NUM_CTRS];
`endif
    logic [63:0]     beat_data_s;
    logic [63:0]     tdata_r;
    logic            tvalid_r;
    logic            tlast_r;
    logic            busy_r;
    logic [31:0]     seq_r;
    logic [31:0]     dropped_r;
    logic            expire_s;
    logic            req_s;
    logic            hs_s;
    logic            last_s;

    assign expire_s = enable & (timer_r == TIMER_LAST);
    assign req_s    = trigger | expire_s;
    assign hs_s     = tvalid_r & axis_out_tready;
    assign last_s   = (idx_r == LAST_IDX);

    assign axis_out_tdata   = tdata_r;
    assign axis_out_tvalid  = tvalid_r;
    assign axis_out_tlast   = tlast_r;
    assign busy             = busy_r;
    assign report_seq       = seq_r;
    assign dropped_triggers = dropped_r;

    // Period timer: free-runs while enabled, reloads after the expiry cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            timer_r <= '0;
        end else if (!enable || expire_s) begin
            timer_r <= '0;
        end else begin
            timer_r <= timer_r + {{(PW-1){1'b0}}, 1'b1};
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE:   if (req_s) state_s = ST_SNAP; else state_s = ST_IDLE;
            ST_SNAP:   state_s = ST_HEADER;
            ST_HEADER: if (hs_s) state_s = ST_SEND; else state_s = ST_HEADER;
            ST_SEND:   if (hs_s && last_s) state_s = ST_IDLE; else state_s = ST_SEND;
            default:   state_s = ST_IDLE;
        endcase
    end

    // Index and payload of the beat to present after the current handshake.
    always_comb begin
        next_idx_s = '0;
        case (state_r)
            ST_SEND: if (last_s) next_idx_s = '0; else next_idx_s = idx_r + {{(IW-1){1'b0}}, 1'b1};
            default: next_idx_s = '0;
        endcase
`ifdef RX_CTR_DELTA_EN
        beat_data_s = snap_r[next_idx_s] - prev_r[next_idx_s];
`else
        beat_data_s = snap_r[next_idx_s];
`endif
    end

    // Snapshot bank(s): every counter captured in the single SNAP cycle, order port-major bad/fd/md/fc/oth.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_CTRS; i++) begin
                snap_r[i] <= 64'd0;
`ifdef RX_CTR_DELTA_EN
                prev_r[i] <= 64'd0;
`endif
            end
        end else if (state_r == ST_SNAP) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                snap_r[5*p+0] <= bad_packets_in[64*p +: 64];
                snap_r[5*p+1] <= fd_packets_in[64*p +: 64];
                snap_r[5*p+2] <= md_packets_in[64*p +: 64];
                snap_r[5*p+3] <= fc_packets_in[64*p +: 64];
                snap_r[5*p+4] <= oth_packets_in[64*p +: 64];
            end
`ifdef RX_CTR_DELTA_EN
            for (int i = 0; i < NUM_CTRS; i++) begin
                prev_r[i] <= snap_r[i];
            end
`endif
        end
    end

    // Stream output registers; held while stalled, so tvalid never follows tready combinationally.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tdata_r  <= 64'd0;
            tvalid_r <= 1'b0;
            tlast_r  <= 1'b0;
            idx_r    <= '0;
            seq_r    <= 32'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    tvalid_r <= 1'b0;
                    tlast_r  <= 1'b0;
                end
                ST_SNAP: begin
                    seq_r    <= seq_r + 32'd1;
                    tdata_r  <= {16'hC7A5, 8'(NUM_PORTS), HDR_FLAGS, seq_r + 32'd1};
                    tvalid_r <= 1'b1;
                    tlast_r  <= 1'b0;
                    idx_r    <= '0;
                end
                ST_HEADER: begin
                    if (hs_s) begin
                        tdata_r <= beat_data_s;
                        tlast_r <= 1'b0;
                    end
                end
                ST_SEND: begin
                    if (hs_s) begin
                        if (last_s) begin
                            tvalid_r <= 1'b0;
                            tlast_r  <= 1'b0;
                        end else begin
                            idx_r   <= next_idx_s;
                            tdata_r <= beat_data_s;
                            tlast_r <= (next_idx_s == LAST_IDX);
                        end
                    end
                end
                default: begin
                    tvalid_r <= 1'b0;
                    tlast_r  <= 1'b0;
                end
            endcase
        end
    end

    // Busy flag and saturating count of requests that arrive outside IDLE.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            busy_r    <= 1'b0;
            dropped_r <= 32'd0;
        end else begin
            busy_r <= (state_s != ST_IDLE);
            if (req_s && (state_r != ST_IDLE) && (dropped_r != 32'hFFFF_FFFF)) begin
                dropped_r <= dropped_r + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_rx_ctr_reporter.sv
// Self-checking bench for rx_ctr_reporter: directed steps with a beat scoreboard.
module tb_rx_ctr_reporter;

    localparam int NP = 2;
    localparam int NC = 5 * NP;

    logic             clk = 1'b0;
    logic             resetn;
    logic             enable;
    logic             trigger;
    logic [64*NP-1:0] bad_in, fd_in, md_in, fc_in, oth_in;
    logic [63:0]      tdata;
    logic             tvalid, tlast, tready;
    logic             busy;
    logic [31:0]      report_seq, dropped;

    rx_ctr_reporter #(.NUM_PORTS(NP), .PERIOD_CYCLES(16), .PW(32)) dut (
        .clk(clk), .resetn(resetn), .enable(enable), .trigger(trigger),
        .bad_packets_in(bad_in), .fd_packets_in(fd_in), .md_packets_in(md_in),
        .fc_packets_in(fc_in), .oth_packets_in(oth_in),
        .axis_out_tdata(tdata), .axis_out_tvalid(tvalid), .axis_out_tlast(tlast),
        .axis_out_tready(tready), .busy(busy), .report_seq(report_seq),
        .dropped_triggers(dropped)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] data;
        logic        last;
    } beat_t;

    beat_t       exp_q[$];
    logic [63:0] cur [NC];
    logic [63:0] prev_m [NC];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    bit          toggle_ready = 1'b0;
`ifdef RX_CTR_DELTA_EN
    localparam logic [7:0] FLAGS = 8'h01;
`else
    localparam logic [7:0] FLAGS = 8'h00;
`endif

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive_inputs();
        for (int p = 0; p < NP; p++) begin
            bad_in[64*p +: 64] = cur[5*p+0];
            fd_in[64*p +: 64]  = cur[5*p+1];
            md_in[64*p +: 64]  = cur[5*p+2];
            fc_in[64*p +: 64]  = cur[5*p+3];
            oth_in[64*p +: 64] = cur[5*p+4];
        end
    endtask

    // Expected frame from the bench's own counter values and previous-snapshot model.
    task automatic push_frame(input logic [31:0] seq);
        beat_t b;
        b.data = {16'hC7A5, 8'd2, FLAGS, seq};
        b.last = 1'b0;
        exp_q.push_back(b);
        for (int i = 0; i < NC; i++) begin
`ifdef RX_CTR_DELTA_EN
            b.data = cur[i] - prev_m[i];
            prev_m[i] = cur[i];
`else
            b.data = cur[i];
`endif
            b.last = (i == NC - 1);
            exp_q.push_back(b);
        end
    endtask

    // One clock: check the presented beat at negedge, then advance to just after posedge.
    task automatic tick();
        beat_t b;
        @(negedge clk);
        if (resetn && tvalid) begin
            if (exp_q.size() == 0) begin
                chk("extra_beat", {63'd0, tvalid}, 64'd0);
            end else begin
                b = exp_q[0];
                chk("beat_data", tdata, b.data);
                chk("beat_last", {63'd0, tlast}, {63'd0, b.last});
                if (tready) void'(exp_q.pop_front());
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (toggle_ready) tready = ~tready;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || busy || tvalid) && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic pulse_trigger();
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
    endtask

    initial begin
        int hdr_t [3];
        int nh;
        bit prev_v;

        resetn = 1'b0; enable = 1'b0; trigger = 1'b0; tready = 1'b1;
        for (int i = 0; i < NC; i++) begin
            cur[i] = 64'(i + 1);
            prev_m[i] = 64'd0;
        end
        drive_inputs();
        repeat (3) tick();
        chk("rst_tvalid", {63'd0, tvalid}, 64'd0);
        chk("rst_tlast", {63'd0, tlast}, 64'd0);
        chk("rst_tdata", tdata, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_seq", {32'd0, report_seq}, 64'd0);
        chk("rst_dropped", {32'd0, dropped}, 64'd0);
        resetn = 1'b1;
        tick();

        // Single triggered report with 2-cycle header latency.
        push_frame(32'd1);
        pulse_trigger();
        chk("lat_snap_cycle", {63'd0, tvalid}, 64'd0);
        tick();
        chk("lat_header_valid", {63'd0, tvalid}, 64'd1);
        wait_idle(40);
        chk("seq_after_r1", {32'd0, report_seq}, 64'd1);

        // Stalling sink; inputs change during SEND but the snapshot is reported.
        push_frame(32'd2);
        toggle_ready = 1'b1;
        pulse_trigger();
        repeat (4) tick();
        for (int i = 0; i < NC; i++) cur[i] = 64'd99;
        drive_inputs();
        wait_idle(80);
        toggle_ready = 1'b0;
        tready = 1'b1;
        chk("seq_after_r2", {32'd0, report_seq}, 64'd2);

        // Periodic reports every 16 cycles.
        push_frame(32'd3);
        push_frame(32'd4);
        push_frame(32'd5);
        enable = 1'b1;
        cyc = 0;
        nh = 0;
        prev_v = 1'b0;
        while (nh < 3 && cyc < 100) begin
            tick();
            if (tvalid && !prev_v) begin
                hdr_t[nh] = cyc;
                nh++;
            end
            prev_v = tvalid;
        end
        enable = 1'b0;
        chk("periodic_headers", 64'(nh), 64'd3);
        chk("periodic_first", 64'(hdr_t[0]), 64'd17);
        chk("periodic_gap1", 64'(hdr_t[1] - hdr_t[0]), 64'd16);
        chk("periodic_gap2", 64'(hdr_t[2] - hdr_t[1]), 64'd16);
        wait_idle(40);
        chk("periodic_seq", {32'd0, report_seq}, 64'd5);
        chk("periodic_dropped", {32'd0, dropped}, 64'd0);

        // Requests during SEND and on the final-beat handshake are dropped.
        push_frame(32'd6);
        pulse_trigger();
        repeat (4) tick();
        pulse_trigger();
        nh = 0;
        while (!(tvalid && tlast) && nh < 30) begin
            tick();
            nh++;
        end
        chk("final_beat_seen", {63'd0, tlast}, 64'd1);
        pulse_trigger();
        wait_idle(30);
        repeat (20) tick();
        chk("dropped_count", {32'd0, dropped}, 64'd2);
        chk("dropped_seq", {32'd0, report_seq}, 64'd6);
        chk("dropped_idle", {63'd0, busy}, 64'd0);

        // Asynchronous reset in the middle of SEND.
        push_frame(32'd7);
        pulse_trigger();
        repeat (6) tick();
        chk("pre_reset_busy", {63'd0, busy}, 64'd1);
        resetn = 1'b0;
        #1;
        chk("async_tvalid", {63'd0, tvalid}, 64'd0);
        chk("async_busy", {63'd0, busy}, 64'd0);
        chk("async_seq", {32'd0, report_seq}, 64'd0);
        chk("async_dropped", {32'd0, dropped}, 64'd0);
        exp_q.delete();
        for (int i = 0; i < NC; i++) prev_m[i] = 64'd0;
        repeat (2) tick();
        resetn = 1'b1;
        tick();
        push_frame(32'd1);
        pulse_trigger();
        wait_idle(40);
        chk("post_reset_seq", {32'd0, report_seq}, 64'd1);

        // Two reports with port0 fd 100 -> 250 (delta 150 when the delta bank is built).
        for (int i = 0; i < NC; i++) cur[i] = 64'd0;
        cur[1] = 64'd100;
        drive_inputs();
        push_frame(32'd2);
        pulse_trigger();
        wait_idle(40);
        cur[1] = 64'd250;
        drive_inputs();
        push_frame(32'd3);
        pulse_trigger();
        wait_idle(40);
        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
